// File: rtl/gray_pattern_checker_pkg.sv
// Shared definitions for the Gray-code LED pattern checker and the
// generator-side benches.
//   state_t      : checker state (IDLE, ACQUIRE, LOCKED, STALLED)
//   gray2bin     : Gray-to-binary decode on a MAX_W-bit vector
//   is_one_hot   : true when exactly one bit of the argument is set
package gray_pattern_checker_pkg;

  localparam int MAX_W      = 32;  // widest vector the helpers accept
  localparam int GOOD_CNT_W = 4;   // holds LOCK_COUNT values 1..15

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_STALLED = 2'd3
  } state_t;

  // Prefix-XOR from the MSB down: b[i] = ^g[MAX_W-1:i].
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = g;
    for (int sh = 1; sh < MAX_W; sh = sh * 2) begin
      b = b ^ (b >> sh);
    end
    return b;
  endfunction

  function automatic logic is_one_hot(input logic [MAX_W-1:0] v);
    return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/gray_pattern_checker_sync.sv
// sync_2ff: WIDTH-bit two-flop synchronizer for a possibly asynchronous
// input vector. Each bit has its own two-stage chain; both stages reset to 0.
// Ports:
//   clk    system clock
//   rst_n  synchronous reset, active low
//   d      asynchronous input vector
//   q      synchronized output (two clk cycles of latency)
module sync_2ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic s1_reg;
    logic s2_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_reg <= 1'b0;
        s2_reg <= 1'b0;
      end else begin
        s1_reg <= d[gi];
        s2_reg <= s1_reg;
      end
    end

    assign q[gi] = s2_reg;
  end

endmodule

// File: rtl/gray_pattern_checker.sv
// gray_pattern_checker: receive side of the LED Gray-code test pattern.
// Synchronizes vec_in, detects changes, decodes Gray to binary and checks
// that every update is exactly +1 modulo 2^ACTIVE_BITS with only one bit
// flipping and all unused upper bits zero. Tracks lock, counts bad steps
// and flags a stalled pattern.
// Ports:
//   clk        system clock
//   rst_n      synchronous reset, active low
//   vec_in     Gray pattern under test (may be asynchronous)
//   locked     high in LOCKED state
//   stall      high in STALLED state
//   err_pulse  one-cycle pulse per bad step seen in ACQUIRE/LOCKED
//   err_count  saturating count of bad steps
//   value      last decoded binary value
module gray_pattern_checker
  import gray_pattern_checker_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int ACTIVE_BITS  = 5,
  parameter int LOCK_COUNT   = 4,
  parameter int TIMEOUT_LOG2 = 21,
  parameter int ERR_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       vec_in,
  output logic                   locked,
  output logic                   stall,
  output logic                   err_pulse,
  output logic [ERR_W-1:0]       err_count,
  output logic [ACTIVE_BITS-1:0] value
);

  // Timer value one below its all-ones terminal count.
  localparam logic [TIMEOUT_LOG2-1:0] TIMER_LAST = {{(TIMEOUT_LOG2-1){1'b1}}, 1'b0};
  localparam logic [GOOD_CNT_W-1:0]   GOOD_LAST  = GOOD_CNT_W'(LOCK_COUNT - 1);

  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] p_reg;

  state_t                  state_reg,     state_next;
  logic [GOOD_CNT_W-1:0]   good_cnt_reg,  good_cnt_next;
  logic [TIMEOUT_LOG2-1:0] timer_reg,     timer_next;
  logic [ACTIVE_BITS-1:0]  value_reg,     value_next;
  logic [ERR_W-1:0]        err_count_reg, err_count_next;
  logic                    err_pulse_reg, err_pulse_next;

  logic                   change;
  logic                   upper_zero;
  logic                   one_flip;
  logic [ACTIVE_BITS-1:0] b_new;
  logic                   step_good;
  logic                   bad_step;

  sync_2ff #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (vec_in),
    .q     (s2)
  );

  assign change     = (s2 != p_reg);
  assign upper_zero = ((s2 >> ACTIVE_BITS) == '0);
  assign one_flip   = is_one_hot(MAX_W'(s2 ^ p_reg));
  assign b_new      = ACTIVE_BITS'(gray2bin(MAX_W'(s2[ACTIVE_BITS-1:0])));
  // The ACTIVE_BITS-wide add wraps naturally, so max -> 0 is a good step.
  assign step_good  = upper_zero && one_flip && (b_new == value_reg + ACTIVE_BITS'(1));

  always_comb begin
    state_next     = state_reg;
    good_cnt_next  = good_cnt_reg;
    timer_next     = timer_reg;
    value_next     = value_reg;
    err_count_next = err_count_reg;
    err_pulse_next = 1'b0;
    bad_step       = 1'b0;

    if (change) begin
      // A change always beats a coincident timeout.
      timer_next = '0;
      value_next = b_new;
      unique case (state_reg)
        ST_IDLE, ST_STALLED: begin
          // Re-synchronize on whatever value arrives; no step check.
          state_next    = ST_ACQUIRE;
          good_cnt_next = '0;
        end
        ST_ACQUIRE: begin
          if (step_good) begin
            if (good_cnt_reg == GOOD_LAST) begin
              state_next    = ST_LOCKED;
              good_cnt_next = '0;
            end else begin
              good_cnt_next = good_cnt_reg + GOOD_CNT_W'(1);
            end
          end else begin
            good_cnt_next = '0;
            bad_step      = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!step_good) begin
            state_next    = ST_ACQUIRE;
            good_cnt_next = '0;
            bad_step      = 1'b1;
          end
        end
        default: begin
          state_next    = ST_IDLE;
          good_cnt_next = '0;
        end
      endcase
    end else if (state_reg != ST_STALLED) begin
      // Timer freezes at all-ones while stalled.
      timer_next = timer_reg + TIMEOUT_LOG2'(1);
      if (timer_reg == TIMER_LAST) begin
        state_next    = ST_STALLED;
        good_cnt_next = '0;
      end
    end

    if (bad_step) begin
      err_pulse_next = 1'b1;
      if (err_count_reg != '1) begin
        err_count_next = err_count_reg + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_reg         <= '0;
      state_reg     <= ST_IDLE;
      good_cnt_reg  <= '0;
      timer_reg     <= '0;
      value_reg     <= '0;
      err_count_reg <= '0;
      err_pulse_reg <= 1'b0;
    end else begin
      p_reg         <= s2;
      state_reg     <= state_next;
      good_cnt_reg  <= good_cnt_next;
      timer_reg     <= timer_next;
      value_reg     <= value_next;
      err_count_reg <= err_count_next;
      err_pulse_reg <= err_pulse_next;
    end
  end

  assign locked    = (state_reg == ST_LOCKED);
  assign stall     = (state_reg == ST_STALLED);
  assign err_pulse = err_pulse_reg;
  assign err_count = err_count_reg;
  assign value     = value_reg;

endmodule
